mvu: RTL and testbench
======================

Name: mvu

Overview:
- Binary/ternary N x N matrix-vector unit for a quantized-NN accelerator; one instance per MVU slot.
- Owns a weight memory, NDBANK data banks, an N-lane product/accumulate/max-pool datapath and a writeback quantizer.
- Data banks are shared by three read/write client pairs: datapath (d), inter-MVU interconnect (i), host controller (c). Fixed-priority arbitration.

Parameters:
N, 64, vector length / lanes; power of 2. Derived: BWBANKA=9, BDBANKA=14, BDBANKW=2N.
NDBANK, 32, number of 512-word x 2N-bit data banks (NDBANK*512 <= 2^14).

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
mul_mode  in  2  product mode: 00 zero, 01 AND, 10 XNOR(+-1), 11 {0,1}x{+-1}
acc_clr/acc_sh  in  1 each  accumulator clear-load / shift-accumulate
max_en/max_clr/max_pool  in  1 each  max update / max restart / writeback source select (1=max, 0=acc)
rdw_addr  in  9  weight word address, used with rdd_en
wrw_en/wrw_addr/wrw_word  in  1/9/N*N  weight write; row i = bits [iN +: N]
rdd_en/rdd_addr in 1/14, rdd_grnt out 1  datapath vector read
wrd_en/wrd_addr in 1/14, wrd_grnt out 1  datapath result write
rdi_en/rdi_addr in 1/14, rdi_grnt out 1, rdi_word out 2N  interconnect read
wri_en/wri_addr/wri_word in 1/14/2N, wri_grnt out 1  interconnect write
rdc_en/rdc_addr in 1/14, rdc_grnt out 1, rdc_word out 2N  controller read
wrc_en/wrc_addr/wrc_word in 1/14/2N, wrc_grnt out 1  controller write

Behaviour:
- Data address: [13:9] bank, [8:0] word. Addresses with bank >= NDBANK: reads return 0, writes dropped, grant still given.
- One read and one write per cycle. Read priority c > i > d; write c > i > d. grnt = en & no higher-priority en; combinational. Ungranted request is dropped; the client retries.
- Granted read: data registered, valid next cycle. rdc_word/rdi_word hold their last granted data until the next grant for that client.
- Read and write of the same address in one cycle returns old data.
- Weight write takes effect next cycle.
- Compute stage 0 (cycle t): granted rdd read plus weight read at rdw_addr. mul_mode and acc/max controls are sampled at t and piped with the data.
  - If rdd_en is not granted at t, stage 1 at t+1 does nothing.
- Stage 1 (t+1): x = D[N-1:0]. Lane i: p_i = sum_j f(W[i][j], x[j]), 8-bit signed.
  - f by mode: 00 -> 0; 01 -> w&x; 10 -> +1 if w==x else -1; 11 -> x ? (w ? +1 : -1) : 0.
  - Accumulator update A_i (16-bit signed, wraps), priority clr > sh:
    - acc_clr: A_i <= p_i
    - acc_sh: A_i <= (A_i << 1) + p_i
    - otherwise: A_i <= A_i + p_i
- Stage 2 (t+2), only when max_en (piped):
  - max_clr: M_i <= A_i
  - otherwise: M_i <= max(M_i, A_i), signed compare
- Writeback: when wrd_en & wrd_grnt, write word with lane i at bits [2i+1:2i] = clamp(S_i, 0, 3), where S = max_pool ? M : A, using register values at that edge.
- Reset (async, any time): A, M, read-data registers, pipeline valids <= 0; rdc_word = rdi_word = 0. In-flight operations are discarded. Memory contents are not reset.

Test Plan:
- Controller write 0x...A5 to address 0x0205, read back -> rdc_grnt=1, rdc_word=written value one cycle later.
- Simultaneous rdc_en, rdi_en, rdd_en -> only rdc_grnt=1. Simultaneous wrc_en, wri_en -> wri_grnt=0, memory holds controller data.
- Weights all 1, x all 1, mode 10, acc_clr -> A_i=64. Mode 01 with x = 0 -> A_i=0.
- Bit-serial: mode 01, acc_clr then acc_sh with p=3 each step -> A_i = 3 then 9. wrd write -> lanes = 3 (clamped).
- Max pool sequence A = 5, -2, 7 with max_en (first with max_clr), max_pool=1 writeback -> M=7, lane value 3. A=-2 with max_clr -> lane value 0.
- Assert rst_n low mid-accumulation -> A=M=0 immediately, rdc_word=0, next product restarts from zero.

Source files
------------

// File: rtl/mvu.sv
// Binary/ternary N x N matrix-vector unit: weight memory, shared data banks arbitrated
// c > i > d, N-lane product/accumulate/max-pool datapath and 2-bit writeback quantizer.
module mvu #(
   parameter  int N       = 64,
   parameter  int NDBANK  = 32,
   localparam int BWBANKA = 9,
   localparam int BDBANKA = 14,
   localparam int BDBANKW = 2 * N
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mul_mode,
   input  logic               acc_clr,
   input  logic               acc_sh,
   input  logic               max_en,
   input  logic               max_clr,
   input  logic               max_pool,
   input  logic [BWBANKA-1:0] rdw_addr,
   input  logic               wrw_en,
   input  logic [BWBANKA-1:0] wrw_addr,
   input  logic [N*N-1:0]     wrw_word,
   input  logic               rdd_en,
   input  logic [BDBANKA-1:0] rdd_addr,
   output logic               rdd_grnt,
   input  logic               wrd_en,
   input  logic [BDBANKA-1:0] wrd_addr,
   output logic               wrd_grnt,
   input  logic               rdi_en,
   input  logic [BDBANKA-1:0] rdi_addr,
   output logic               rdi_grnt,
   output logic [BDBANKW-1:0] rdi_word,
   input  logic               wri_en,
   input  logic [BDBANKA-1:0] wri_addr,
   input  logic [BDBANKW-1:0] wri_word,
   output logic               wri_grnt,
   input  logic               rdc_en,
   input  logic [BDBANKA-1:0] rdc_addr,
   output logic               rdc_grnt,
   output logic [BDBANKW-1:0] rdc_word,
   input  logic               wrc_en,
   input  logic [BDBANKA-1:0] wrc_addr,
   input  logic [BDBANKW-1:0] wrc_word,
   output logic               wrc_grnt
);

   localparam int          DDEPTH = NDBANK * 512;
   localparam int          DAW    = $clog2(DDEPTH);
   localparam logic [5:0]  NDB    = 6'(NDBANK);

   logic [BDBANKW-1:0] dmem [DDEPTH];
   logic [N*N-1:0]     wmem [2**BWBANKA];

   logic [BDBANKA-1:0] rd_addr, wr_addr;
   logic [BDBANKW-1:0] wr_data, wb_word;
   logic               rd_any, wr_any, rd_ok, wr_ok;

   logic [BDBANKW-1:0] rd_word_reg, rdc_hold_reg, rdi_hold_reg;
   logic               rdc_vld_reg, rdi_vld_reg;
   logic [N*N-1:0]     w_reg;
   logic               s1_vld_reg, s1_clr_reg, s1_sh_reg, s1_men_reg, s1_mclr_reg;
   logic [1:0]         s1_mode_reg;
   logic               s2_vld_reg, s2_mclr_reg;
   logic [N-1:0]       x_vec;

   assign rdc_grnt = rdc_en;
   assign rdi_grnt = rdi_en & ~rdc_en;
   assign rdd_grnt = rdd_en & ~rdc_en & ~rdi_en;
   assign wrc_grnt = wrc_en;
   assign wri_grnt = wri_en & ~wrc_en;
   assign wrd_grnt = wrd_en & ~wrc_en & ~wri_en;

   assign rd_any  = rdc_en | rdi_en | rdd_en;
   assign wr_any  = wrc_en | wri_en | wrd_en;
   assign rd_addr = rdc_en ? rdc_addr : (rdi_en ? rdi_addr : rdd_addr);
   assign wr_addr = wrc_en ? wrc_addr : (wri_en ? wri_addr : wrd_addr);
   assign wr_data = wrc_en ? wrc_word : (wri_en ? wri_word : wb_word);
   // Out-of-range banks still get a grant; the access itself is suppressed here.
   assign rd_ok   = {1'b0, rd_addr[BDBANKA-1:9]} < NDB;
   assign wr_ok   = {1'b0, wr_addr[BDBANKA-1:9]} < NDB;

   always_ff @(posedge clk) begin
      if (wr_any && wr_ok)
         dmem[wr_addr[DAW-1:0]] <= wr_data;
      if (wrw_en)
         wmem[wrw_addr] <= wrw_word;
      if (rdd_grnt)
         w_reg <= wmem[rdw_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_word_reg  <= '0;
         rdc_vld_reg  <= 1'b0;
         rdi_vld_reg  <= 1'b0;
         rdc_hold_reg <= '0;
         rdi_hold_reg <= '0;
         s1_vld_reg   <= 1'b0;
         s1_mode_reg  <= 2'b00;
         s1_clr_reg   <= 1'b0;
         s1_sh_reg    <= 1'b0;
         s1_men_reg   <= 1'b0;
         s1_mclr_reg  <= 1'b0;
         s2_vld_reg   <= 1'b0;
         s2_mclr_reg  <= 1'b0;
      end else begin
         if (rd_any)
            rd_word_reg <= rd_ok ? dmem[rd_addr[DAW-1:0]] : '0;
         rdc_vld_reg  <= rdc_grnt;
         rdi_vld_reg  <= rdi_grnt;
         rdc_hold_reg <= rdc_word;
         rdi_hold_reg <= rdi_word;
         s1_vld_reg   <= rdd_grnt;
         s1_mode_reg  <= mul_mode;
         s1_clr_reg   <= acc_clr;
         s1_sh_reg    <= acc_sh;
         s1_men_reg   <= max_en;
         s1_mclr_reg  <= max_clr;
         s2_vld_reg   <= s1_vld_reg & s1_men_reg;
         s2_mclr_reg  <= s1_mclr_reg;
      end
   end

   // The shared read register feeds whichever client was granted last cycle.
   assign rdc_word = rdc_vld_reg ? rd_word_reg : rdc_hold_reg;
   assign rdi_word = rdi_vld_reg ? rd_word_reg : rdi_hold_reg;
   assign x_vec    = rd_word_reg[N-1:0];

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [N-1:0] w_row;
      logic [7:0]   cnt_and, cnt_xnor, cnt_x, prod;
      logic [15:0]  prod_ext, acc_next, acc_reg, max_reg, wb_src;

      assign w_row = w_reg[gi*N +: N];

      // Products reduce to popcounts: XNOR is 2*matches-N, ternary is 2*(w&x)-|x|.
      always_comb begin
         cnt_and  = '0;
         cnt_xnor = '0;
         cnt_x    = '0;
         for (int j = 0; j < N; j++) begin
            cnt_and  = cnt_and  + {7'b0, w_row[j] & x_vec[j]};
            cnt_xnor = cnt_xnor + {7'b0, ~(w_row[j] ^ x_vec[j])};
            cnt_x    = cnt_x    + {7'b0, x_vec[j]};
         end
         case (s1_mode_reg)
            2'b01:   prod = cnt_and;
            2'b10:   prod = (cnt_xnor << 1) - 8'(N);
            2'b11:   prod = (cnt_and << 1) - cnt_x;
            default: prod = '0;
         endcase
      end

      assign prod_ext = {{8{prod[7]}}, prod};

      always_comb begin
         if (s1_clr_reg)
            acc_next = prod_ext;
         else if (s1_sh_reg)
            acc_next = {acc_reg[14:0], 1'b0} + prod_ext;
         else
            acc_next = acc_reg + prod_ext;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            acc_reg <= '0;
            max_reg <= '0;
         end else begin
            if (s1_vld_reg)
               acc_reg <= acc_next;
            if (s2_vld_reg && (s2_mclr_reg || ($signed(acc_reg) > $signed(max_reg))))
               max_reg <= acc_reg;
         end
      end

      assign wb_src = max_pool ? max_reg : acc_reg;
      assign wb_word[2*gi +: 2] = wb_src[15] ? 2'd0 : ((|wb_src[14:2]) ? 2'd3 : wb_src[1:0]);
   end

endmodule

// File: tb/tb_mvu.sv
// Randomized + directed bench for mvu: reads are checked by a queue-based monitor,
// datapath results are checked through writeback and controller readback.
module tb_mvu;
   localparam int N   = 64;
   localparam int W   = 2 * N;
   localparam int NDB = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [1:0]     mul_mode = '0;
   logic           acc_clr = 0, acc_sh = 0, max_en = 0, max_clr = 0, max_pool = 0;
   logic [8:0]     rdw_addr = '0, wrw_addr = '0;
   logic           wrw_en = 0;
   logic [N*N-1:0] wrw_word = '0;
   logic           rdd_en = 0, wrd_en = 0, rdi_en = 0, wri_en = 0, rdc_en = 0, wrc_en = 0;
   logic [13:0]    rdd_addr = '0, wrd_addr = '0, rdi_addr = '0, wri_addr = '0, rdc_addr = '0, wrc_addr = '0;
   logic [W-1:0]   wri_word = '0, wrc_word = '0;
   logic           rdd_grnt, wrd_grnt, rdi_grnt, wri_grnt, rdc_grnt, wrc_grnt;
   logic [W-1:0]   rdi_word, rdc_word;

   always #5 clk = ~clk;

   mvu #(.N(N), .NDBANK(NDB)) dut (
      .clk(clk), .rst_n(rst_n), .mul_mode(mul_mode), .acc_clr(acc_clr), .acc_sh(acc_sh),
      .max_en(max_en), .max_clr(max_clr), .max_pool(max_pool), .rdw_addr(rdw_addr),
      .wrw_en(wrw_en), .wrw_addr(wrw_addr), .wrw_word(wrw_word),
      .rdd_en(rdd_en), .rdd_addr(rdd_addr), .rdd_grnt(rdd_grnt),
      .wrd_en(wrd_en), .wrd_addr(wrd_addr), .wrd_grnt(wrd_grnt),
      .rdi_en(rdi_en), .rdi_addr(rdi_addr), .rdi_grnt(rdi_grnt), .rdi_word(rdi_word),
      .wri_en(wri_en), .wri_addr(wri_addr), .wri_word(wri_word), .wri_grnt(wri_grnt),
      .rdc_en(rdc_en), .rdc_addr(rdc_addr), .rdc_grnt(rdc_grnt), .rdc_word(rdc_word),
      .wrc_en(wrc_en), .wrc_addr(wrc_addr), .wrc_word(wrc_word), .wrc_grnt(wrc_grnt)
   );

   int n_vec = 0, n_fail = 0;

   // Reference model state
   logic [W-1:0]   dmem_m [int];
   logic [N*N-1:0] wmem_m [int];
   int             acc_m [N];
   int             max_m [N];
   logic [W-1:0]   cq [$];
   logic [W-1:0]   iq [$];
   logic [W-1:0]   c_exp, i_exp;
   logic           rdc_fire_d = 0, rdi_fire_d = 0;

   task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a grant seen at a rising edge means the word is presented for that cycle.
   always @(posedge clk) begin
      rdc_fire_d <= rdc_en & rdc_grnt;
      rdi_fire_d <= rdi_en & rdi_grnt;
   end

   always @(negedge clk) begin
      if (rdc_fire_d) begin
         if (cq.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL rdc_word unexpected: got %h", rdc_word);
         end else begin
            c_exp = cq.pop_front();
            check("rdc_word", rdc_word, c_exp);
         end
      end
      if (rdi_fire_d) begin
         if (iq.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL rdi_word unexpected: got %h", rdi_word);
         end else begin
            i_exp = iq.pop_front();
            check("rdi_word", rdi_word, i_exp);
         end
      end
   end

   function automatic logic [W-1:0] exp_rd(int a);
      if ((a >> 9) >= NDB || !dmem_m.exists(a)) return '0;
      return dmem_m[a];
   endfunction

   function automatic void model_wr(int a, logic [W-1:0] d);
      if ((a >> 9) < NDB) dmem_m[a] = d;
   endfunction

   // Products straight from the per-element definition of f.
   function automatic void model_op(int wa, int da, int mode, bit clr, bit sh, bit men, bit mclr);
      logic [N*N-1:0] wv = wmem_m[wa];
      logic [W-1:0]   dv = dmem_m[da];
      for (int i = 0; i < N; i++) begin
         int p = 0;
         int a;
         for (int j = 0; j < N; j++) begin
            bit w = wv[i*N + j];
            bit x = dv[j];
            case (mode)
               1: p += (w & x) ? 1 : 0;
               2: p += (w == x) ? 1 : -1;
               3: p += x ? (w ? 1 : -1) : 0;
               default: p += 0;
            endcase
         end
         if (clr)     a = p;
         else if (sh) a = 2 * acc_m[i] + p;
         else         a = acc_m[i] + p;
         acc_m[i] = int'(shortint'(a));
         if (men) begin
            if (mclr || acc_m[i] > max_m[i]) max_m[i] = acc_m[i];
         end
      end
   endfunction

   function automatic logic [W-1:0] wb_model(bit pool);
      logic [W-1:0] r = '0;
      for (int i = 0; i < N; i++) begin
         int s = pool ? max_m[i] : acc_m[i];
         int q = (s < 0) ? 0 : ((s > 3) ? 3 : s);
         r[2*i +: 2] = 2'(q);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic wr_c(int a, logic [W-1:0] d);
      wrc_en = 1; wrc_addr = 14'(a); wrc_word = d; #1;
      check("wrc_grnt", W'(wrc_grnt), W'(1));
      model_wr(a, d);
      tick(); wrc_en = 0;
   endtask

   task automatic rd_c(int a);
      rdc_en = 1; rdc_addr = 14'(a); #1;
      check("rdc_grnt", W'(rdc_grnt), W'(1));
      cq.push_back(exp_rd(a));
      tick(); rdc_en = 0;
   endtask

   task automatic rd_i(int a);
      rdi_en = 1; rdi_addr = 14'(a); #1;
      check("rdi_grnt", W'(rdi_grnt), W'(1));
      iq.push_back(exp_rd(a));
      tick(); rdi_en = 0;
   endtask

   task automatic wr_w(int a, logic [N*N-1:0] w);
      wrw_en = 1; wrw_addr = 9'(a); wrw_word = w;
      wmem_m[a] = w;
      tick(); wrw_en = 0;
   endtask

   task automatic dp_op(int wa, int da, int mode, bit clr, bit sh, bit men, bit mclr);
      rdd_en = 1; rdd_addr = 14'(da); rdw_addr = 9'(wa); mul_mode = 2'(mode);
      acc_clr = clr; acc_sh = sh; max_en = men; max_clr = mclr; #1;
      check("rdd_grnt", W'(rdd_grnt), W'(1));
      model_op(wa, da, mode, clr, sh, men, mclr);
      tick();
      rdd_en = 0; acc_clr = 0; acc_sh = 0; max_en = 0; max_clr = 0;
   endtask

   // Drains the pipeline, writes back the quantized lanes, then reads them back.
   task automatic wb(int a, bit pool);
      idle(3);
      wrd_en = 1; wrd_addr = 14'(a); max_pool = pool; #1;
      check("wrd_grnt", W'(wrd_grnt), W'(1));
      model_wr(a, wb_model(pool));
      tick(); wrd_en = 0; max_pool = 0;
      rd_c(a);
   endtask

   function automatic logic [N*N-1:0] rand_w();
      logic [N*N-1:0] r;
      for (int k = 0; k < N*N/32; k++) r[k*32 +: 32] = $urandom & $urandom & $urandom;
      return r;
   endfunction

   function automatic logic [W-1:0] rand_d();
      logic [W-1:0] r;
      for (int k = 0; k < W/32; k++) r[k*32 +: 32] = (k < 2) ? ($urandom & $urandom & $urandom) : $urandom;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]   pat, va, vb;
      logic [N*N-1:0] ones;
      for (int i = 0; i < N; i++) begin acc_m[i] = 0; max_m[i] = 0; end
      pat  = {16{8'hA5}};
      ones = '1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rdc_word_reset", rdc_word, '0);
      check("rdi_word_reset", rdi_word, '0);
      rst_n = 1;
      tick();

      // Controller write/readback, hold, interconnect read
      wr_c(14'h0205, pat);
      rd_c(14'h0205);
      rd_i(14'h0205);
      idle(2);
      check("rdc_word_hold", rdc_word, pat);

      // Out-of-range bank: granted, dropped, reads zero, no aliasing onto 0x0205
      wr_c(14'h2205, ~pat);
      rd_c(14'h2205);
      rd_c(14'h0205);

      // Read and write priority
      va = rand_d(); vb = rand_d();
      wr_c(14'h0300, va);
      wr_c(14'h0301, vb);
      rdc_en = 1; rdc_addr = 14'h0300; rdi_en = 1; rdi_addr = 14'h0301;
      rdd_en = 1; rdd_addr = 14'h0301; mul_mode = 2'b10; acc_clr = 1; #1;
      check("rdc_grnt_prio", W'(rdc_grnt), W'(1));
      check("rdi_grnt_prio", W'(rdi_grnt), W'(0));
      check("rdd_grnt_prio", W'(rdd_grnt), W'(0));
      cq.push_back(exp_rd(14'h0300));
      tick();
      rdc_en = 0; rdi_en = 0; rdd_en = 0; acc_clr = 0;
      wrc_en = 1; wrc_addr = 14'h0302; wrc_word = va;
      wri_en = 1; wri_addr = 14'h0302; wri_word = vb;
      wrd_en = 1; wrd_addr = 14'h0302; #1;
      check("wri_grnt_prio", W'(wri_grnt), W'(0));
      check("wrd_grnt_prio", W'(wrd_grnt), W'(0));
      model_wr(14'h0302, va);
      tick();
      wrc_en = 0; wri_en = 0; wrd_en = 0;
      rd_c(14'h0302);
      wri_en = 1; wri_addr = 14'h0303; wri_word = vb; wrd_en = 1; wrd_addr = 14'h0303; #1;
      check("wri_grnt_over_d", W'(wri_grnt), W'(1));
      check("wrd_grnt_under_i", W'(wrd_grnt), W'(0));
      model_wr(14'h0303, vb);
      tick();
      wri_en = 0; wrd_en = 0;
      rd_i(14'h0303);

      // Directed datapath vectors
      wr_w(1, ones);
      wr_w(2, '0);
      wr_c(14'h0010, '1);
      wr_c(14'h0011, '0);
      wr_c(14'h0012, W'(128'h7));
      wr_c(14'h0013, W'(128'h1F));
      wr_c(14'h0014, W'(128'h3));
      wr_c(14'h0015, W'(128'h7F));
      wr_c(14'h0016, W'(128'h1));
      dp_op(1, 14'h0010, 2, 1, 0, 0, 0);   // XNOR all ones -> 64
      wb(14'h0400, 0);
      dp_op(1, 14'h0011, 1, 1, 0, 0, 0);   // AND with x = 0 -> 0
      wb(14'h0401, 0);
      dp_op(1, 14'h0016, 1, 1, 0, 0, 0);   // -> 1
      wb(14'h0409, 0);
      dp_op(1, 14'h0012, 1, 1, 0, 0, 0);   // bit-serial: 3
      wb(14'h0402, 0);
      dp_op(1, 14'h0012, 1, 0, 1, 0, 0);   // then 2*3+3 = 9
      wb(14'h0403, 0);
      dp_op(1, 14'h0013, 3, 1, 0, 1, 1);   // A = 5, M restarts
      dp_op(2, 14'h0014, 3, 1, 0, 1, 0);   // A = -2
      dp_op(1, 14'h0015, 3, 1, 0, 1, 0);   // A = 7
      wb(14'h0404, 1);
      dp_op(2, 14'h0014, 3, 1, 0, 1, 1);   // M restarts at -2
      wb(14'h0405, 1);
      wb(14'h0406, 0);

      // Reset during accumulation with an operation in flight
      dp_op(1, 14'h0012, 1, 1, 0, 0, 0);
      dp_op(1, 14'h0015, 3, 1, 0, 1, 1);
      rd_c(14'h0205);
      idle(2);
      dp_op(1, 14'h0013, 1, 1, 0, 0, 0);
      rst_n = 0; #1;
      check("rdc_word_async_reset", rdc_word, '0);
      check("rdi_word_async_reset", rdi_word, '0);
      for (int i = 0; i < N; i++) begin acc_m[i] = 0; max_m[i] = 0; end
      idle(2);
      @(negedge clk); rst_n = 1;
      tick();
      dp_op(1, 14'h0016, 1, 0, 0, 1, 0);   // accumulates from zero: A = M = 1
      wb(14'h0407, 0);
      wb(14'h0408, 1);

      // Randomized traffic
      for (int k = 0; k < 4; k++) begin
         wr_w(10 + k, rand_w());
         wr_c(14'h0500 + k, rand_d());
      end
      for (int it = 0; it < 60; it++) begin
         int r = $urandom_range(0, 9);
         int k = $urandom_range(0, 3);
         if (r <= 5)
            dp_op(10 + $urandom_range(0, 3), 14'h0500 + k, $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
         else if (r <= 7)
            wb(14'h0600 + (it % 16), $urandom_range(0, 1) == 1);
         else if (r == 8)
            rd_i(14'h0500 + k);
         else
            wr_c(14'h0500 + k, rand_d());
      end

      idle(3);
      check("rdc_queue_drained", W'(cq.size()), '0);
      check("rdi_queue_drained", W'(iq.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
